// File: rtl/vend_seq_ctrl.sv
// Credit-and-dispense sequencer: accumulates coin credit, dispenses a product over
// a req/ack handshake, then pays the remainder out as one change coin per cycle.
module vend_seq_ctrl #(
    parameter int unsigned CREDIT_W     = 6,
    parameter int unsigned MAX_CREDIT   = 31,
    parameter int unsigned PRICE0       = 3,
    parameter int unsigned PRICE1       = 5,
    parameter int unsigned PRICE2       = 7,
    parameter int unsigned PRICE3       = 10,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin1,
    input  logic                coin2,
    input  logic                coin5,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic [1:0]          disp_sel,
    output logic                ret1,
    output logic                ret2,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                err_insufficient,
    output logic                coin_reject,
    output logic                fault
);

    localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

    state_t              state;
    logic [ACK_W-1:0]    ack_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [3:0]          coin_sum;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_fits;
    logic                coin_any;
    logic                activity;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] disp_price;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    // One extra bit on the sum so the overflow test cannot wrap.
    always_comb begin
        coin_sum   = {3'b000, coin1} + {2'b00, coin2, 1'b0} + (coin5 ? 4'd5 : 4'd0);
        credit_sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_sum);
        coin_fits  = credit_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
        coin_any   = coin1 | coin2 | coin5;
        activity   = coin_any | sel_valid | cancel;
        sel_price  = price_of(sel);
        disp_price = price_of(disp_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ack_cnt          <= '0;
            idle_cnt         <= '0;
            disp_req         <= 1'b0;
            disp_sel         <= '0;
            ret1             <= 1'b0;
            ret2             <= 1'b0;
            credit           <= '0;
            busy             <= 1'b0;
            err_insufficient <= 1'b0;
            coin_reject      <= 1'b0;
            fault            <= 1'b0;
        end else begin
            err_insufficient <= 1'b0;
            coin_reject      <= 1'b0;
            fault            <= 1'b0;
            ret1             <= 1'b0;
            ret2             <= 1'b0;
            case (state)
                IDLE: begin
                    if (coin_any) begin
                        if (coin_fits) credit <= credit_sum[CREDIT_W-1:0];
                        else           coin_reject <= 1'b1;
                    end
                    if (activity || credit == '0) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        idle_cnt <= '0;
                        state    <= CHANGE;
                        busy     <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // Selection is judged on the credit held before this cycle's coins.
                    if (cancel) begin
                        if (credit != '0) begin
                            state <= CHANGE;
                            busy  <= 1'b1;
                        end
                    end else if (sel_valid) begin
                        if (credit >= sel_price) begin
                            state    <= DISPENSE;
                            busy     <= 1'b1;
                            disp_req <= 1'b1;
                            disp_sel <= sel;
                            ack_cnt  <= '0;
                        end else begin
                            err_insufficient <= 1'b1;
                        end
                    end
                end
                DISPENSE: begin
                    if (coin_any) coin_reject <= 1'b1;
                    if (disp_ack) begin
                        credit   <= credit - disp_price;
                        disp_req <= 1'b0;
                        if (credit != disp_price) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        disp_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= CHANGE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                CHANGE: begin
                    if (coin_any) coin_reject <= 1'b1;
                    if (credit >= CREDIT_W'(2)) begin
                        ret2   <= 1'b1;
                        credit <= credit - CREDIT_W'(2);
                        if (credit == CREDIT_W'(2)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        ret1   <= 1'b1;
                        credit <= credit - CREDIT_W'(1);
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
